// File: rtl/rv32i_pkg.sv
// Shared types and constants for the RV32I core, its boot loader and benches.
package rv32i_pkg;

  typedef enum logic [1:0] {
    StLoad,
    StWrite,
    StDone,
    StErr
  } imem_loader_state_t;

  localparam logic [31:0] HALT_INSTR = 32'h0010_0073;

endpackage

// File: rtl/imem_loader.sv
// Boot-time loader: assembles a little-endian byte stream into words, fills imem from address 0
// and holds the core in reset until done. Optional checksum word: IMEM_LOADER_CHECKSUM_EN.
module imem_loader
  import rv32i_pkg::*;
#(
  parameter int unsigned IMEM_DEPTH = 1024,
  parameter int unsigned ADDR_W     = $clog2(IMEM_DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [7:0]        s_data,
  input  logic              s_last,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              core_rst,
  output logic              done,
  output logic              err,
  output logic [ADDR_W:0]   instr_count
);

  localparam logic [ADDR_W:0] DepthCount = IMEM_DEPTH[ADDR_W:0];

  imem_loader_state_t r_state, w_state_nxt;

  logic [1:0]        r_byte_cnt;
  logic [31:0]       r_word;
  logic              r_last;
  logic [ADDR_W-1:0] r_wr_ptr;
  logic [ADDR_W:0]   r_instr_count;

  logic [31:0] w_word_nxt;
  logic        w_accept;
  logic        w_complete;
  logic        w_commit;      // word in the WRITE slot goes to memory
  logic        w_last_ok;     // final word may release the core
  logic        w_would_write; // completing word will need a memory slot
  logic        w_overflow;

`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [31:0] r_sum;

  assign w_commit      = !r_last;
  assign w_last_ok     = (r_sum == r_word);
  assign w_would_write = !s_last;
`else
  assign w_commit      = 1'b1;
  assign w_last_ok     = 1'b1;
  assign w_would_write = 1'b1;
`endif

  assign w_accept    = (r_state == StLoad) && s_valid;
  assign w_complete  = w_accept && ((r_byte_cnt == 2'd3) || s_last);
  assign w_overflow  = (r_instr_count == DepthCount) && w_would_write;
  assign instr_count = r_instr_count;

  always_comb begin
    w_word_nxt = r_word;
    unique case (r_byte_cnt)
      2'd0: w_word_nxt[7:0]   = s_data;
      2'd1: w_word_nxt[15:8]  = s_data;
      2'd2: w_word_nxt[23:16] = s_data;
      2'd3: w_word_nxt[31:24] = s_data;
    endcase
  end

  always_comb begin
    w_state_nxt = r_state;
    s_ready     = 1'b0;
    imem_we     = 1'b0;
    imem_addr   = '0;
    imem_wdata  = '0;
    core_rst    = 1'b1;
    done        = 1'b0;
    err         = 1'b0;
    unique case (r_state)
      StLoad: begin
        s_ready = 1'b1;
        if (w_complete) begin
          w_state_nxt = w_overflow ? StErr : StWrite;
        end
      end
      StWrite: begin
        imem_we    = w_commit;
        imem_addr  = r_wr_ptr;
        imem_wdata = r_word;
        if (r_last) begin
          w_state_nxt = w_last_ok ? StDone : StErr;
        end else begin
          w_state_nxt = StLoad;
        end
      end
      StDone: begin
        core_rst = 1'b0;
        done     = 1'b1;
      end
      StErr: begin
        err = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= StLoad;
      r_byte_cnt    <= 2'd0;
      r_word        <= '0;
      r_last        <= 1'b0;
      r_wr_ptr      <= '0;
      r_instr_count <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      r_sum         <= '0;
`endif
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        r_word     <= w_word_nxt;
        r_byte_cnt <= r_byte_cnt + 2'd1;
        r_last     <= s_last;
      end
      if (r_state == StWrite) begin
        r_word     <= '0;
        r_byte_cnt <= 2'd0;
        if (w_commit) begin
          r_wr_ptr      <= r_wr_ptr + 1'b1;
          r_instr_count <= r_instr_count + 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
          r_sum         <= r_sum + r_word;
`endif
        end
      end
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader with a write scoreboard; covers both checksum build options.
module tb_imem_loader;
  import rv32i_pkg::*;

  localparam int unsigned Depth = 4;
  localparam int unsigned AW    = $clog2(Depth);

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          s_valid = 1'b0;
  logic          s_ready;
  logic [7:0]    s_data = 8'h00;
  logic          s_last = 1'b0;
  logic          imem_we;
  logic [AW-1:0] imem_addr;
  logic [31:0]   imem_wdata;
  logic          core_rst;
  logic          done;
  logic          err;
  logic [AW:0]   instr_count;

  always #5 clk = ~clk;

  imem_loader #(
    .IMEM_DEPTH(Depth)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .s_valid    (s_valid),
    .s_ready    (s_ready),
    .s_data     (s_data),
    .s_last     (s_last),
    .imem_we    (imem_we),
    .imem_addr  (imem_addr),
    .imem_wdata (imem_wdata),
    .core_rst   (core_rst),
    .done       (done),
    .err        (err),
    .instr_count(instr_count)
  );

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [31:0]   data;
  } wr_t;

  int          n_cmp = 0;
  int          n_err = 0;
  int          we_count = 0;
  int          exp_ptr = 0;
  wr_t         exp_q[$];
  logic [31:0] mem[Depth];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Memory side: every write must match the next scoreboard entry.
  always @(negedge clk) begin
    wr_t e;
    if (imem_we) begin
      we_count++;
      mem[imem_addr] = imem_wdata;
      if (exp_q.size() == 0) begin
        check("unexpected_write", exp_q.size(), 1);
      end else begin
        e = exp_q.pop_front();
        check("wr_addr", imem_addr, e.addr);
        check("wr_data", imem_wdata, e.data);
      end
    end
  end

  task automatic do_reset();
    rst = 1'b1;
    s_valid = 1'b0;
    s_last = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    exp_q.delete();
    exp_ptr = 0;
  endtask

  task automatic expect_write(input logic [31:0] data);
    wr_t e;
    e.addr = exp_ptr[AW-1:0];
    e.data = data;
    exp_q.push_back(e);
    exp_ptr++;
  endtask

  // Returns #1 after the edge that accepted the byte.
  task automatic send_byte(input logic [7:0] b, input logic last, input bit rnd);
    int guard = 0;
    if (rnd) begin
      while ($urandom_range(1, 0) == 0 && guard < 8) begin
        s_valid = 1'b0;
        @(posedge clk);
        #1;
        guard++;
      end
    end
    s_valid = 1'b1;
    s_data = b;
    s_last = last;
    guard = 0;
    while (!s_ready && guard < 20) begin
      @(posedge clk);
      #1;
      guard++;
    end
    if (!s_ready) check("ready_timeout", s_ready, 1);
    @(posedge clk);
    #1;
    s_valid = 1'b0;
    s_last = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w, input bit last, input bit wr, input bit rnd);
    if (wr) expect_write(w);
    for (int i = 0; i < 4; i++) send_byte(w[8*i+:8], last && (i == 3), rnd);
  endtask

  initial begin
    logic [31:0] img[4];
    int we0;

    do_reset();
    check("rst_s_ready", s_ready, 1);
    check("rst_imem_we", imem_we, 0);
    check("rst_imem_addr", imem_addr, 0);
    check("rst_imem_wdata", imem_wdata, 0);
    check("rst_core_rst", core_rst, 1);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    check("rst_instr_count", instr_count, 0);

`ifndef IMEM_LOADER_CHECKSUM_EN
    // Two-instruction program, last byte on the halt word.
    send_word(32'h00A0_0513, 1'b0, 1'b1, 1'b0);
    send_word(HALT_INSTR, 1'b1, 1'b1, 1'b0);
    check("prog_we_in_write", imem_we, 1);
    check("prog_addr_in_write", imem_addr, 1);
    check("prog_done_early", done, 0);
    check("prog_core_rst_early", core_rst, 1);
    @(posedge clk);
    #1;
    check("prog_done", done, 1);
    check("prog_core_rst", core_rst, 0);
    check("prog_count", instr_count, 2);
    check("prog_s_ready", s_ready, 0);
    check("prog_mem0", mem[0], 32'h00A0_0513);
    check("prog_mem1", mem[1], 32'h0010_0073);
    check("prog_q_empty", exp_q.size(), 0);

    // Early last on byte 6: upper lanes of word 1 padded with zero.
    do_reset();
    expect_write(32'h0403_0201);
    expect_write(32'h0000_0605);
    for (int i = 1; i <= 6; i++) send_byte(8'(i), i == 6, 1'b0);
    @(posedge clk);
    #1;
    check("pad_done", done, 1);
    check("pad_count", instr_count, 2);
    check("pad_mem1", mem[1], 32'h0000_0605);
    check("pad_q_empty", exp_q.size(), 0);

    // Random s_valid gaps must not change the image.
    do_reset();
    img = '{32'h1122_3344, 32'h5566_7788, 32'h99AA_BBCC, 32'hDDEE_FF00};
    we0 = we_count;
    for (int i = 0; i < 4; i++) send_word(img[i], i == 3, 1'b1, 1'b1);
    @(posedge clk);
    #1;
    check("rnd_we_pulses", we_count - we0, 4);
    check("rnd_done", done, 1);
    check("rnd_count", instr_count, 4);
    for (int i = 0; i < 4; i++) check($sformatf("rnd_mem%0d", i), mem[i], img[i]);

    // Reset after two words, then reload a fresh image.
    do_reset();
    send_word(32'hAAAA_0001, 1'b0, 1'b1, 1'b0);
    send_word(32'hAAAA_0002, 1'b0, 1'b1, 1'b0);
    @(posedge clk);
    #1;
    check("mid_count_before", instr_count, 2);
    do_reset();
    check("mid_count_reset", instr_count, 0);
    img = '{32'hC0DE_0000, 32'hC0DE_0001, 32'hC0DE_0002, 32'hC0DE_0003};
    for (int i = 0; i < 4; i++) send_word(img[i], i == 3, 1'b1, 1'b0);
    @(posedge clk);
    #1;
    check("mid_done", done, 1);
    check("mid_count", instr_count, 4);
    for (int i = 0; i < 4; i++) check($sformatf("mid_mem%0d", i), mem[i], img[i]);
`else
    // Checksum build: 1 + 2 == 3 passes, checksum word is not written.
    send_word(32'd1, 1'b0, 1'b1, 1'b0);
    send_word(32'd2, 1'b0, 1'b1, 1'b0);
    send_word(32'd3, 1'b1, 1'b0, 1'b0);
    check("cks_no_we", imem_we, 0);
    @(posedge clk);
    #1;
    check("cks_done", done, 1);
    check("cks_err", err, 0);
    check("cks_core_rst", core_rst, 0);
    check("cks_count", instr_count, 2);
    check("cks_mem1", mem[1], 32'd2);
    check("cks_q_empty", exp_q.size(), 0);

    do_reset();
    send_word(32'd1, 1'b0, 1'b1, 1'b0);
    send_word(32'd2, 1'b0, 1'b1, 1'b0);
    send_word(32'd4, 1'b1, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    check("cks_bad_err", err, 1);
    check("cks_bad_done", done, 0);
    check("cks_bad_core_rst", core_rst, 1);

    do_reset();
    send_word(32'd0, 1'b1, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    check("cks_zero_done", done, 1);
    check("cks_zero_count", instr_count, 0);
`endif

    // Overflow: fifth data word with a full memory.
    do_reset();
    we0 = we_count;
    for (int i = 0; i < 4; i++) send_word(32'h0F00_0000 + i, 1'b0, 1'b1, 1'b0);
    send_word(32'hDEAD_BEEF, 1'b0, 1'b0, 1'b0);
    check("ovf_err", err, 1);
    check("ovf_core_rst", core_rst, 1);
    check("ovf_s_ready", s_ready, 0);
    check("ovf_done", done, 0);
    check("ovf_count", instr_count, 4);
    repeat (3) @(posedge clk);
    #1;
    check("ovf_err_held", err, 1);
    check("ovf_we_pulses", we_count - we0, 4);
    check("ovf_q_empty", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule
